ghost_motion_ctrl: RTL and testbench

- Per-frame motion and appearance controller for one 16x16 ghost sprite source.
- Generates the sprite origin (x0, y0) and the 4-bit ctrl word: orientation in bits [1:0], body colour select in bits [3:2].
- Each step moves the ghost along its current direction, reverses at screen edges and takes pseudo-random turns.
- On a hit, it hides the ghost, waits, then respawns it at a pseudo-random location. It sits between the frame counter and the sprite source in the video top.

---
 rtl/ghost_pkg.sv | 26 ++
 rtl/lfsr16.sv | 23 ++
 rtl/ghost_motion_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_ghost_motion_ctrl.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/ghost_pkg.sv
// Shared types and constants for the ghost sprite controllers.
package ghost_pkg;

    typedef enum logic [1:0] {
        DIR_RIGHT = 2'b00,
        DIR_DOWN  = 2'b01,
        DIR_LEFT  = 2'b10,
        DIR_UP    = 2'b11
    } dir_t;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        STEP,
        DEAD
    } ghost_state_t;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_MASK = 16'hB400;

    // Flipping bit 1 of the encoding turns right<->left and down<->up.
    function automatic dir_t reverse_dir(input dir_t d);
        return dir_t'(d ^ 2'b10);
    endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Galois LFSR; a non-zero seed keeps it out of the all-zero lock-up state.
module lfsr16
    import ghost_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    output logic [15:0] q
);

    logic [15:0] lfsr_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_MASK : 16'h0000);
        end
    end

    assign q = lfsr_q;

endmodule

// File: rtl/ghost_motion_ctrl.sv
// Per-frame motion/appearance controller for one 16x16 ghost: walks, bounces off edges,
// turns pseudo-randomly, and hides/respawns after a hit.
module ghost_motion_ctrl
    import ghost_pkg::*;
#(
    parameter int H_RES          = 640,
    parameter int V_RES          = 480,
    parameter int SPRITE_SIZE    = 16,
    parameter int START_X        = 312,
    parameter int START_Y        = 232,
    parameter int TURN_MOVES     = 32,
    parameter int RESPAWN_FRAMES = 60
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        frame_start,
    input  logic        en,
    input  logic [3:0]  speed,
    input  logic [5:0]  period,
    input  logic [1:0]  color_sel,
    input  logic        hit,
    output logic [10:0] x0,
    output logic [10:0] y0,
    output logic [3:0]  ctrl,
    output logic        visible
);

    localparam logic signed [11:0] X_LIM = 12'(H_RES - SPRITE_SIZE);
    localparam logic signed [11:0] Y_LIM = 12'(V_RES - SPRITE_SIZE);
    localparam int MC_W = $clog2(TURN_MOVES + 1);
    localparam int DC_W = $clog2(RESPAWN_FRAMES + 1);

    ghost_state_t    state_q, state_d;
    logic [10:0]     x0_q, x0_d;
    logic [10:0]     y0_q, y0_d;
    dir_t            dir_q, dir_d;
    logic [1:0]      color_q, color_d;
    logic            visible_q, visible_d;
    logic [5:0]      frame_cnt_q, frame_cnt_d;
    logic [MC_W-1:0] move_cnt_q, move_cnt_d;
    logic [DC_W-1:0] dead_cnt_q, dead_cnt_d;

    logic [15:0] lfsr;

    lfsr16 u_lfsr (
        .clk   (clk),
        .reset (reset),
        .q     (lfsr)
    );

    // Single-axis step datapath: only the coordinate along the current direction moves.
    logic               step_vert;
    logic               step_back;
    logic signed [11:0] pos_cur;
    logic signed [11:0] pos_lim;
    logic signed [11:0] pos_sum;
    logic signed [11:0] delta;
    logic [10:0]        pos_new;
    logic               edge_hit;

    always_comb begin
        step_vert = (dir_q == DIR_DOWN) || (dir_q == DIR_UP);
        step_back = (dir_q == DIR_LEFT) || (dir_q == DIR_UP);
        delta     = {8'b0, speed};
        pos_cur   = step_vert ? {1'b0, y0_q} : {1'b0, x0_q};
        pos_lim   = step_vert ? Y_LIM : X_LIM;
        pos_sum   = step_back ? (pos_cur - delta) : (pos_cur + delta);
        pos_new   = pos_sum[10:0];
        edge_hit  = 1'b0;
        if (step_back && pos_sum[11]) begin
            pos_new  = '0;
            edge_hit = 1'b1;
        end else if (!step_back && (pos_sum > pos_lim)) begin
            pos_new  = pos_lim[10:0];
            edge_hit = 1'b1;
        end
    end

    logic            hit_kill;
    logic [6:0]      frame_inc;
    logic [5:0]      eff_period;
    logic [MC_W-1:0] move_inc;
    logic [DC_W-1:0] dead_inc;

    assign hit_kill   = hit && (state_q != DEAD);
    assign frame_inc  = {1'b0, frame_cnt_q} + 7'd1;
    assign eff_period = (period == 6'd0) ? 6'd1 : period;
    assign move_inc   = move_cnt_q + MC_W'(1);
    assign dead_inc   = dead_cnt_q + DC_W'(1);

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        x0_d        = x0_q;
        y0_d        = y0_q;
        dir_d       = dir_q;
        color_d     = color_q;
        visible_d   = visible_q;
        frame_cnt_d = frame_cnt_q;
        move_cnt_d  = move_cnt_q;
        dead_cnt_d  = dead_cnt_q;

        if (frame_start) begin
            color_d = color_sel;
        end

        case (state_q)
            IDLE: begin
                if (!hit_kill && en) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (!hit_kill) begin
                    if (!en) begin
                        state_d = IDLE;
                    end else if (frame_start) begin
                        if (frame_inc >= {1'b0, eff_period}) begin
                            frame_cnt_d = '0;
                            state_d     = STEP;
                        end else begin
                            frame_cnt_d = frame_inc[5:0];
                        end
                    end
                end
            end
            STEP: begin
                if (!hit_kill) begin
                    if (step_vert) begin
                        y0_d = pos_new;
                    end else begin
                        x0_d = pos_new;
                    end
                    if (edge_hit) begin
                        dir_d = reverse_dir(dir_q);
                    end
                    // An edge bounce outranks the scheduled random turn.
                    if (move_inc == MC_W'(TURN_MOVES)) begin
                        move_cnt_d = '0;
                        if (!edge_hit) begin
                            dir_d = dir_t'(lfsr[1:0]);
                        end
                    end else begin
                        move_cnt_d = move_inc;
                    end
                    state_d = en ? WAIT : IDLE;
                end
            end
            DEAD: begin
                if (frame_start) begin
                    if (dead_inc == DC_W'(RESPAWN_FRAMES)) begin
                        x0_d        = {2'b00, lfsr[8:0]};
                        y0_d        = {3'b000, lfsr[15:8]};
                        dir_d       = dir_t'(lfsr[1:0]);
                        visible_d   = 1'b1;
                        move_cnt_d  = '0;
                        frame_cnt_d = '0;
                        state_d     = en ? WAIT : IDLE;
                    end else begin
                        dead_cnt_d = dead_inc;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (hit_kill) begin
            state_d    = DEAD;
            visible_d  = 1'b0;
            dead_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            x0_q        <= 11'(START_X);
            y0_q        <= 11'(START_Y);
            dir_q       <= DIR_RIGHT;
            color_q     <= 2'b00;
            visible_q   <= 1'b1;
            frame_cnt_q <= '0;
            move_cnt_q  <= '0;
            dead_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            x0_q        <= x0_d;
            y0_q        <= y0_d;
            dir_q       <= dir_d;
            color_q     <= color_d;
            visible_q   <= visible_d;
            frame_cnt_q <= frame_cnt_d;
            move_cnt_q  <= move_cnt_d;
            dead_cnt_q  <= dead_cnt_d;
        end
    end

    assign x0      = x0_q;
    assign y0      = y0_q;
    assign ctrl    = {color_q, dir_q};
    assign visible = visible_q;

endmodule

// File: tb/tb_ghost_motion_ctrl.sv
// Directed bench for ghost_motion_ctrl: table of walk phases plus hand-written hit/respawn/reset sequences.
module tb_ghost_motion_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        frame_start = 1'b0;
    logic        en = 1'b0;
    logic [3:0]  speed = 4'd0;
    logic [5:0]  period = 6'd0;
    logic [1:0]  color_sel = 2'd0;
    logic        hit = 1'b0;
    logic [10:0] x0;
    logic [10:0] y0;
    logic [3:0]  ctrl;
    logic        visible;

    int n_cmp = 0;
    int n_err = 0;

    ghost_motion_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .frame_start (frame_start),
        .en          (en),
        .speed       (speed),
        .period      (period),
        .color_sel   (color_sel),
        .hit         (hit),
        .x0          (x0),
        .y0          (y0),
        .ctrl        (ctrl),
        .visible     (visible)
    );

    always #5 clk = ~clk;

    // Reference LFSR: Galois, mask 16'hB400, seed 16'hACE1, advances every clock.
    logic [15:0] m_lfsr;
    always @(posedge clk or posedge reset) begin
        if (reset) m_lfsr <= 16'hACE1;
        else       m_lfsr <= {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // One frame_start pulse; returns the LFSR value seen during the following (STEP) cycle.
    task automatic pulse_frame(output logic [15:0] lfsr_step);
        @(negedge clk);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        lfsr_step = m_lfsr;
        repeat (3) @(negedge clk);
    endtask

    // Expected single step along dir with edge clamp/reversal.
    function automatic void model_step(input int x, input int y, input logic [1:0] d, input int spd,
                                       output int nx, output int ny, output logic [1:0] nd);
        nx = x; ny = y; nd = d;
        case (d)
            2'd0: begin nx = x + spd; if (nx > 624) begin nx = 624; nd = 2'd2; end end
            2'd1: begin ny = y + spd; if (ny > 464) begin ny = 464; nd = 2'd3; end end
            2'd2: begin nx = x - spd; if (nx < 0) begin nx = 0; nd = 2'd0; end end
            default: begin ny = y - spd; if (ny < 0) begin ny = 0; nd = 2'd1; end end
        endcase
    endfunction

    typedef struct {
        logic [3:0]  speed;
        logic [5:0]  period;
        int          frames;
        logic [1:0]  color;
        logic [10:0] exp_x;
        logic [10:0] exp_y;
        logic [1:0]  exp_dir;
    } row_t;

    row_t rows[10];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] lstep;
        logic [15:0] lresp;
        int          ex, ey;
        logic [1:0]  ed;
        logic [10:0] save_x, save_y;

        // Walk phases from (312,232) heading right; 31 steps total, no random turn yet.
        rows[0] = '{4'd4,  6'd2, 2,  2'd0, 11'd316, 11'd232, 2'd0};
        rows[1] = '{4'd4,  6'd2, 4,  2'd1, 11'd324, 11'd232, 2'd0};
        rows[2] = '{4'd0,  6'd1, 3,  2'd2, 11'd324, 11'd232, 2'd0};
        rows[3] = '{4'd15, 6'd0, 4,  2'd3, 11'd384, 11'd232, 2'd0};
        rows[4] = '{4'd8,  6'd3, 6,  2'd0, 11'd400, 11'd232, 2'd0};
        rows[5] = '{4'd15, 6'd1, 10, 2'd1, 11'd550, 11'd232, 2'd0};
        rows[6] = '{4'd14, 6'd1, 5,  2'd2, 11'd620, 11'd232, 2'd0};
        rows[7] = '{4'd8,  6'd1, 1,  2'd3, 11'd624, 11'd232, 2'd2};
        rows[8] = '{4'd8,  6'd1, 1,  2'd0, 11'd616, 11'd232, 2'd2};
        rows[9] = '{4'd2,  6'd1, 2,  2'd2, 11'd612, 11'd232, 2'd2};

        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("reset_x0", x0, 312);
        check("reset_y0", y0, 232);
        check("reset_ctrl", ctrl, 0);
        check("reset_visible", visible, 1);

        for (int i = 0; i < 5; i++) pulse_frame(lstep);
        check("idle_x0_hold", x0, 312);
        check("idle_y0_hold", y0, 232);

        en = 1'b1;
        repeat (2) @(negedge clk);
        for (int r = 0; r < 10; r++) begin
            speed     = rows[r].speed;
            period    = rows[r].period;
            color_sel = rows[r].color;
            for (int f = 0; f < rows[r].frames; f++) pulse_frame(lstep);
            check($sformatf("row%0d_x0", r), x0, rows[r].exp_x);
            check($sformatf("row%0d_y0", r), y0, rows[r].exp_y);
            check($sformatf("row%0d_ctrl", r), ctrl, {rows[r].color, rows[r].exp_dir});
            check($sformatf("row%0d_visible", r), visible, 1);
        end

        // Step 32: move left by 4, then heading comes from the LFSR sampled in that STEP cycle.
        speed = 4'd4;
        pulse_frame(lstep);
        check("turn32_x0", x0, 608);
        check("turn32_dir", ctrl[1:0], lstep[1:0]);
        check("turn32_color", ctrl[3:2], 2);

        // Colour change mid-frame waits for the next frame_start.
        en = 1'b0;
        repeat (3) @(negedge clk);
        color_sel = 2'b01;
        repeat (4) @(negedge clk);
        check("color_midframe_hold", ctrl[3:2], 2);
        pulse_frame(lstep);
        check("color_after_frame", ctrl[3:2], 1);
        check("idle_after_step_x0", x0, 608);

        // Hit: hidden next cycle, a second hit in DEAD is ignored, respawn after 60 frames.
        en = 1'b1;
        period = 6'd1;
        repeat (2) @(negedge clk);
        hit = 1'b1;
        @(negedge clk);
        hit = 1'b0;
        check("hit_visible_low", visible, 0);
        lresp = '0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            frame_start = 1'b1;
            hit = 1'b0;
            if (i == 59) lresp = m_lfsr;
            @(negedge clk);
            frame_start = 1'b0;
            if (i == 20) hit = 1'b1;
            if (i == 58) check("dead_after_59_frames", visible, 0);
        end
        check("respawn_visible", visible, 1);
        check("respawn_x0", x0, {2'b00, lresp[8:0]});
        check("respawn_y0", y0, {3'b000, lresp[15:8]});
        check("respawn_dir", ctrl[1:0], lresp[1:0]);
        repeat (2) @(negedge clk);

        // Back in WAIT: the next frame produces a step from the respawn point.
        model_step(int'(x0), int'(y0), ctrl[1:0], 4, ex, ey, ed);
        pulse_frame(lstep);
        check("post_respawn_x0", x0, ex);
        check("post_respawn_y0", y0, ey);
        check("post_respawn_dir", ctrl[1:0], ed);

        // Hit in the STEP cycle wins: the move is discarded.
        save_x = x0;
        save_y = y0;
        @(negedge clk);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        hit = 1'b1;
        @(negedge clk);
        hit = 1'b0;
        check("step_hit_visible", visible, 0);
        check("step_hit_x0_kept", x0, save_x);
        check("step_hit_y0_kept", y0, save_y);
        for (int i = 0; i < 10; i++) pulse_frame(lstep);
        check("dead_still_hidden", visible, 0);

        // Asynchronous reset while DEAD takes effect without a clock edge.
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("async_reset_x0", x0, 312);
        check("async_reset_y0", y0, 232);
        check("async_reset_ctrl", ctrl, 0);
        check("async_reset_visible", visible, 1);
        #10 reset = 1'b0;
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
